// File: rtl/datamem_arbiter_if.sv
// Two-requester data memory bus: CPU datapath and host/debug port.
// slave = arbiter side, master = requester side.
interface datamem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic              i_cpu_req;
  logic              i_cpu_we;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [DATA_W-1:0] i_cpu_wdata;
  logic              o_cpu_gnt;
  logic              o_cpu_rvalid;
  logic [DATA_W-1:0] o_cpu_rdata;

  logic              i_host_req;
  logic              i_host_we;
  logic [ADDR_W-1:0] i_host_addr;
  logic [DATA_W-1:0] i_host_wdata;
  logic              o_host_gnt;
  logic              o_host_rvalid;
  logic [DATA_W-1:0] o_host_rdata;
  logic              o_host_starved;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
    input  i_host_req, i_host_we, i_host_addr, i_host_wdata,
    output o_host_gnt, o_host_rvalid, o_host_rdata,
    output o_host_starved
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
    output i_host_req, i_host_we, i_host_addr, i_host_wdata,
    input  o_host_gnt, o_host_rvalid, o_host_rdata,
    input  o_host_starved
  );
endinterface

// File: rtl/datamem_arbiter.sv
// Single-port CPU data memory shared by CPU and host.
// CPU wins by default; a starvation counter forces a host grant.
module datamem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  datamem_arbiter_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [7:0]        r_starve_cnt;
  logic              r_cpu_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_host_rdata;

  logic              w_at_limit;
  logic              w_host_win;
  logic              w_cpu_win;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_cpu_rd;
  logic              w_host_rd;

  assign w_at_limit = (r_starve_cnt == LIM);

  always_comb begin
    w_host_win = 1'b0;
    w_cpu_win  = 1'b0;
    w_we       = 1'b0;
    w_addr     = bus.i_cpu_addr;
    w_wdata    = bus.i_cpu_wdata;
    w_cpu_rd   = 1'b0;
    w_host_rd  = 1'b0;
    if (i_rst_n) begin
      w_host_win = bus.i_host_req &&
                   (!bus.i_cpu_req || w_at_limit);
      w_cpu_win  = bus.i_cpu_req && !w_host_win;
    end
    if (w_host_win) begin
      w_addr    = bus.i_host_addr;
      w_wdata   = bus.i_host_wdata;
      w_we      = bus.i_host_we;
      w_host_rd = !bus.i_host_we;
    end else if (w_cpu_win) begin
      w_we      = bus.i_cpu_we;
      w_cpu_rd  = !bus.i_cpu_we;
    end
  end

  // No reset on the array: contents survive a reset.
  always_ff @(posedge i_clk) begin
    if (w_we)
      r_mem[w_addr] <= w_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_starve_cnt  <= '0;
      r_cpu_rvalid  <= 1'b0;
      r_cpu_rdata   <= '0;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      if (w_host_win || !bus.i_host_req)
        r_starve_cnt <= '0;
      else if (w_cpu_win && !w_at_limit)
        r_starve_cnt <= r_starve_cnt + 8'd1;
      r_cpu_rvalid  <= w_cpu_rd;
      r_host_rvalid <= w_host_rd;
      if (w_cpu_rd)
        r_cpu_rdata <= r_mem[w_addr];
      if (w_host_rd)
        r_host_rdata <= r_mem[w_addr];
    end
  end

  // A read granted just before reset must not surface.
  assign bus.o_cpu_gnt      = w_cpu_win;
  assign bus.o_host_gnt     = w_host_win;
  assign bus.o_cpu_rvalid   = r_cpu_rvalid && i_rst_n;
  assign bus.o_host_rvalid  = r_host_rvalid && i_rst_n;
  assign bus.o_cpu_rdata    = r_cpu_rdata;
  assign bus.o_host_rdata   = r_host_rdata;
  assign bus.o_host_starved = w_at_limit && bus.i_host_req;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: cycle model + read-data scoreboard
// plus directed checks of grant patterns and reset behaviour.
module tb_datamem_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  datamem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  datamem_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] m_mem [64] = '{default: '0};
  logic [DW-1:0] q_cpu [$];
  logic [DW-1:0] q_host [$];
  int            m_cnt = 0;
  logic          m_crv = 1'b0;
  logic          m_hrv = 1'b0;
  logic [DW-1:0] m_crd = '0;
  logic [DW-1:0] m_hrd = '0;
  logic          e_hg, e_cg;

  always @(negedge clk) begin
    e_hg = rst_n && bus.i_host_req &&
           (!bus.i_cpu_req || m_cnt == LIM);
    e_cg = rst_n && bus.i_cpu_req && !e_hg;
    chk("cpu_gnt", 32'(bus.o_cpu_gnt), 32'(e_cg));
    chk("host_gnt", 32'(bus.o_host_gnt), 32'(e_hg));
    chk("excl", 32'(bus.o_cpu_gnt & bus.o_host_gnt), 0);
    chk("starved", 32'(bus.o_host_starved),
        32'((m_cnt == LIM) && bus.i_host_req));
    chk("cpu_rv", 32'(bus.o_cpu_rvalid), 32'(m_crv && rst_n));
    chk("host_rv", 32'(bus.o_host_rvalid), 32'(m_hrv && rst_n));
    if (bus.o_cpu_rvalid) begin
      if (q_cpu.size() == 0) chk("cpu_q", 1, 0);
      else chk("cpu_rdata", bus.o_cpu_rdata, q_cpu.pop_front());
    end
    if (bus.o_host_rvalid) begin
      if (q_host.size() == 0) chk("host_q", 1, 0);
      else chk("host_rdata", bus.o_host_rdata, q_host.pop_front());
    end
    chk("cpu_hold", bus.o_cpu_rdata, m_crd);
    chk("host_hold", bus.o_host_rdata, m_hrd);
    if (!rst_n) begin
      m_cnt = 0; m_crv = 0; m_hrv = 0;
      m_crd = '0; m_hrd = '0;
      q_cpu.delete(); q_host.delete();
    end else begin
      if (e_hg || !bus.i_host_req) m_cnt = 0;
      else if (e_cg && m_cnt < LIM) m_cnt++;
      m_crv = e_cg && !bus.i_cpu_we;
      m_hrv = e_hg && !bus.i_host_we;
      if (m_crv) begin
        m_crd = m_mem[bus.i_cpu_addr];
        q_cpu.push_back(m_crd);
      end
      if (m_hrv) begin
        m_hrd = m_mem[bus.i_host_addr];
        q_host.push_back(m_hrd);
      end
      if (e_cg && bus.i_cpu_we)
        m_mem[bus.i_cpu_addr] = bus.i_cpu_wdata;
      if (e_hg && bus.i_host_we)
        m_mem[bus.i_host_addr] = bus.i_host_wdata;
    end
  end

  task automatic drive(input logic r,
                       input logic cr, input logic cw,
                       input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd,
                       input logic hr, input logic hw,
                       input logic [AW-1:0] ha,
                       input logic [DW-1:0] hd);
    @(posedge clk);
    #1;
    rst_n            = r;
    bus.i_cpu_req    = cr;
    bus.i_cpu_we     = cw;
    bus.i_cpu_addr   = ca;
    bus.i_cpu_wdata  = cd;
    bus.i_host_req   = hr;
    bus.i_host_we    = hw;
    bus.i_host_addr  = ha;
    bus.i_host_wdata = hd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.i_cpu_req = 0; bus.i_cpu_we = 0;
    bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0;
    bus.i_host_req = 0; bus.i_host_we = 0;
    bus.i_host_addr = '0; bus.i_host_wdata = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("rst_cpu_rv", 32'(bus.o_cpu_rvalid), 0);
    chk("rst_cpu_rd", bus.o_cpu_rdata, 0);
    chk("rst_host_rd", bus.o_host_rdata, 0);

    drive(1, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("t1_wgnt", 32'(bus.o_cpu_gnt), 1);
    drive(1, 1, 0, 5, 0, 0, 0, 0, 0);
    chk("t1_rgnt", 32'(bus.o_cpu_gnt), 1);
    idle();
    chk("t1_rv", 32'(bus.o_cpu_rvalid), 1);
    chk("t1_rd", bus.o_cpu_rdata, 32'hDEADBEEF);
    idle();
    chk("t1_pulse", 32'(bus.o_cpu_rvalid), 0);

    drive(1, 0, 0, 0, 0, 1, 0, 63, 0);
    chk("t2_gnt", 32'(bus.o_host_gnt), 1);
    idle();
    chk("t2_rv", 32'(bus.o_host_rvalid), 1);
    chk("t2_rd", bus.o_host_rdata, 0);
    chk("t2_cpu_rv", 32'(bus.o_cpu_rvalid), 0);

    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, AW'(i), 0, 1, 0, 63, 0);
      chk("t3_hgnt", 32'(bus.o_host_gnt), 32'(i == 4 || i == 9));
      chk("t3_cgnt", 32'(bus.o_cpu_gnt), 32'(!(i == 4 || i == 9)));
      chk("t3_starv", 32'(bus.o_host_starved), 32'(i == 4 || i == 9));
    end
    idle();

    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 0, 1, 0, 10, 0);
      chk("t4_deny", 32'(bus.o_host_gnt), 0);
    end
    drive(1, 1, 0, 1, 0, 0, 0, 10, 0);
    for (int j = 0; j < 5; j++) begin
      drive(1, 1, 0, 1, 0, 1, 0, 10, 0);
      chk("t4_hgnt", 32'(bus.o_host_gnt), 32'(j == 4));
    end
    idle();

    drive(1, 1, 1, 2, 32'h11, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 2, 0);
    chk("t5_gnt", 32'(bus.o_host_gnt), 1);
    idle();
    chk("t5_rd", bus.o_host_rdata, 32'h11);

    drive(1, 1, 1, 7, 32'hCAFE, 0, 0, 0, 0);
    drive(1, 1, 0, 7, 0, 0, 0, 0, 0);
    chk("t6_rgnt", 32'(bus.o_cpu_gnt), 1);
    drive(0, 1, 1, 7, 32'hBAD, 1, 0, 3, 0);
    chk("t6_rst_rv", 32'(bus.o_cpu_rvalid), 0);
    chk("t6_rst_cg", 32'(bus.o_cpu_gnt), 0);
    chk("t6_rst_hg", 32'(bus.o_host_gnt), 0);
    idle();
    chk("t6_rd0", bus.o_cpu_rdata, 0);
    chk("t6_rv0", 32'(bus.o_cpu_rvalid), 0);
    chk("t6_starv", 32'(bus.o_host_starved), 0);
    drive(1, 1, 0, 7, 0, 0, 0, 0, 0);
    idle();
    chk("t6_keep7", bus.o_cpu_rdata, 32'hCAFE);
    drive(1, 0, 0, 0, 0, 1, 0, 5, 0);
    idle();
    chk("t6_keep5", bus.o_host_rdata, 32'hDEADBEEF);

    for (int k = 0; k < 40; k++)
      drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 15)), $urandom);
    idle();
    idle();
    chk("q_cpu_empty", 32'(q_cpu.size()), 0);
    chk("q_host_empty", 32'(q_host.size()), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
